io_input_conditioner: RTL
=========================

// Module: io_input_conditioner
// PURPOSE
// - Conditions board inputs SW[15:0] and BTNR before they reach the register file's memory-mapped input registers (r26/r27/r28).
// - Provides a 2-FF synchronizer, debouncing, and button rising-edge detect with a wrapping press counter.
// - Sits between the top-level pins and regfile; its outputs drive regfile's SW and BTNR inputs.
// PARAMETERS
// - DEBOUNCE_CYCLES  250000  stable-cycle count required before an output changes (5 ms @ 50 MHz); must be >= 2
// - CNT_W            18      debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
// - clock           in   1   system clock, rising edge
// - ctrl_reset      in   1   asynchronous, active-high reset
// - sw_raw          in   16  raw switch pins
// - btn_raw         in   1   raw BTNR pin
// - btn_ack         in   1   1-cycle acknowledge; clears the pending press
// - sw_clean        out  16  debounced switches (to regfile SW)
// - btn_out         out  1   to regfile BTNR; meaning set by BTN_STICKY_EN
// - btn_rise        out  1   1-cycle pulse on debounced 0->1
// - press_count     out  8   number of debounced presses, wraps modulo 256
// BEHAVIOUR
// - Reset: all sync flops, counters, sw_clean, btn level, pending, btn_rise and press_count go to 0 immediately (async).
// - Sync: sw_raw and btn_raw pass through two flops (s1 -> s2). Only s2 values are used downstream.
// - Button debounce (one counter btn_cnt):
//   - s2 == btn_lvl: btn_cnt <= 0.
//   - else if btn_cnt == DEBOUNCE_CYCLES-1: btn_lvl <= s2 and btn_cnt <= 0.
//   - else btn_cnt++.
//   - A clean step is visible on btn_lvl after edge D+2, counting the sampling edge as edge 1 (D = DEBOUNCE_CYCLES).
//   - Any bounce back to btn_lvl restarts the count from 0.
// - Switch debounce (group, one counter sw_cnt, candidate register sw_cand):
//   - s2 != sw_cand: sw_cand <= s2 and sw_cnt <= 0.
//   - else if sw_cand != sw_clean and sw_cnt == D-1: sw_clean <= sw_cand and sw_cnt <= 0.
//   - else if sw_cand != sw_clean: sw_cnt++.
//   - else sw_cnt <= 0.
//   - Clean step latency is D+3 edges.
//   - Any bit change resets the count for all 16 bits.
//   - Multiple bits changing together update on the same edge.
// - Edge detect: btn_rise = 1 for exactly the cycle after btn_lvl goes 0->1. No pulse on 1->0.
//   - Each pulse increments press_count; 255 wraps to 0.
// - Pending flag: set on btn_rise and cleared on btn_ack.
//   - If both occur in the same cycle, set wins, so no press is lost.
//   - btn_ack while not pending is a no-op.
// - Reset mid-operation: debounce progress is discarded.
//   - If btn_raw is held high through reset release, btn_lvl rises after D+2 edges.
//   - That rise is counted as a press (pulse, count, pending).
// - No combinational path from any input to any output. All outputs are registered.
// CONFIGURATION
// - Macro BTN_STICKY_EN.
//   - Defined: btn_out = pending flag. The processor polls r28 and writes btn_ack (via its I/O decode) after servicing.
//   - Undefined: btn_out = btn_lvl (debounced level). The pending flag and btn_ack logic are not compiled and btn_ack is ignored.
// - btn_rise and press_count are present in both builds.
// TESTING (bench uses DEBOUNCE_CYCLES=4, CNT_W=3)
// - Reset release with raw=0 -> all outputs 0. Assert ctrl_reset mid-count -> outputs 0 within the same cycle, with no clock needed.
// - btn_raw 0->1 held -> btn_lvl=1 after edge 6. btn_rise high one cycle. press_count=1.
// - btn_raw toggles every 2 cycles for 20 cycles then held 1 -> no btn_rise during bouncing; exactly one press counted after settling.
// - sw_raw 0x0000->0xA5C3 held -> sw_clean=0xA5C3 after edge 7.
//   - A bit flip at cycle 4 restarts the count; sw_clean never shows an intermediate value.
// - 256 clean presses -> press_count wraps to 0x00 and btn_rise fires 256 times.
// - With BTN_STICKY_EN: press -> btn_out=1 until btn_ack.
//   - btn_ack in the same cycle as a new btn_rise -> btn_out stays 1.
//   - Without the macro: btn_out follows btn_lvl and btn_ack has no effect.

Source files
------------

// File: rtl/io_input_conditioner.sv
// Board input conditioner: 2-FF synchronizers, debounce for switches and BTNR, and rise detect with a press counter.
// Optional build macro BTN_STICKY_EN: btn_out becomes a pending-press flag cleared by btn_ack.
module io_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [15:0] sw_raw,
    input  logic        btn_raw,
    input  logic        btn_ack,
    output logic [15:0] sw_clean,
    output logic        btn_out,
    output logic        btn_rise,
    output logic [7:0]  press_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      sw_s1_q, sw_s2_q;
    logic             btn_s1_q, btn_s2_q;
    logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
    logic             btn_lvl_q, btn_lvl_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [15:0]      sw_cand_q, sw_cand_d;
    logic [15:0]      sw_clean_q, sw_clean_d;
    logic             btn_rise_q, btn_rise_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    // Button: a single bounce back to the current level restarts the count.
    always_comb begin
        btn_cnt_d = btn_cnt_q;
        btn_lvl_d = btn_lvl_q;
        if (btn_s2_q == btn_lvl_q) begin
            btn_cnt_d = '0;
        end else if (btn_cnt_q == CNT_LAST) begin
            btn_lvl_d = btn_s2_q;
            btn_cnt_d = '0;
        end else begin
            btn_cnt_d = btn_cnt_q + CNT_W'(1);
        end
    end

    // Switches share one counter; any bit change re-arms the candidate so no partial word escapes.
    always_comb begin
        sw_cand_d  = sw_cand_q;
        sw_clean_d = sw_clean_q;
        sw_cnt_d   = sw_cnt_q;
        if (sw_s2_q != sw_cand_q) begin
            sw_cand_d = sw_s2_q;
            sw_cnt_d  = '0;
        end else if (sw_cand_q != sw_clean_q) begin
            if (sw_cnt_q == CNT_LAST) begin
                sw_clean_d = sw_cand_q;
                sw_cnt_d   = '0;
            end else begin
                sw_cnt_d = sw_cnt_q + CNT_W'(1);
            end
        end else begin
            sw_cnt_d = '0;
        end
    end

    assign btn_rise_d  = btn_lvl_d & ~btn_lvl_q;
    assign press_cnt_d = press_cnt_q + 8'(btn_rise_q);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            btn_cnt_q   <= '0;
            btn_lvl_q   <= 1'b0;
            sw_cnt_q    <= '0;
            sw_cand_q   <= '0;
            sw_clean_q  <= '0;
            btn_rise_q  <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            sw_s1_q     <= sw_raw;
            sw_s2_q     <= sw_s1_q;
            btn_s1_q    <= btn_raw;
            btn_s2_q    <= btn_s1_q;
            btn_cnt_q   <= btn_cnt_d;
            btn_lvl_q   <= btn_lvl_d;
            sw_cnt_q    <= sw_cnt_d;
            sw_cand_q   <= sw_cand_d;
            sw_clean_q  <= sw_clean_d;
            btn_rise_q  <= btn_rise_d;
            press_cnt_q <= press_cnt_d;
        end
    end

`ifdef BTN_STICKY_EN
    logic pend_q, pend_d;

    // A new press outranks a simultaneous acknowledge.
    assign pend_d = btn_rise_q | (pend_q & ~btn_ack);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign btn_out = pend_q;
`else
    logic unused_btn_ack;
    assign unused_btn_ack = btn_ack;
    assign btn_out        = btn_lvl_q;
`endif

    assign sw_clean    = sw_clean_q;
    assign btn_rise    = btn_rise_q;
    assign press_count = press_cnt_q;

endmodule
